free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter FL_SIZE, default 32: free-list depth in entries; power of two.
REQ-002 Parameter PR_FIRST, default 32: first physical tag loaded at reset; tags PR_FIRST..PR_FIRST+FL_SIZE-1.
REQ-003 Parameter TAG_W, default 7: physical register tag width.
REQ-004 clock  input  1  one clock; all state updates on posedge clock.
REQ-005 reset  input  1  synchronous, active-low; sampled on posedge clock.
REQ-006 id_dispatch_num  input  2  destination tags consumed by dispatch this cycle (0..2).
REQ-007 rob_retire_num  input  2  tags freed by ROB retire this cycle (0..2).
REQ-008 rob_retire_tag_a  input  TAG_W  first freed tag; valid when rob_retire_num>=1.
REQ-009 rob_retire_tag_b  input  TAG_W  second freed tag; valid when rob_retire_num==2.
REQ-010 fl_pr0  output  TAG_W  tag at head; given to dispatch slot 0.
REQ-011 fl_pr1  output  TAG_W  tag at head+1; given to dispatch slot 1.
REQ-012 fl_cap  output  2  tags available this cycle: min(count,2).
REQ-013 fl_count  output  log2(FL_SIZE)+1  current occupancy.
REQ-014 fl_error  output  1  sticky overflow flag.

Function
REQ-015 Storage SHALL be a circular buffer of FL_SIZE x TAG_W with head, tail (log2(FL_SIZE) bits, wrap modulo FL_SIZE) and count registers.
REQ-016 fl_pr0 = mem[head], fl_pr1 = mem[head+1 mod FL_SIZE], combinational from registered state; no same-cycle bypass from retire inputs.
REQ-017 fl_cap SHALL be 2 when count>=2, else count; fl_count SHALL equal count.
REQ-018 Effective dispatch d = min(id_dispatch_num, fl_cap), id_dispatch_num==3 treated as 2; requests beyond fl_cap SHALL be silently clamped.
REQ-019 On posedge, head SHALL advance by d modulo FL_SIZE.
REQ-020 Effective retire r = rob_retire_num, value 3 treated as 2; tag_a written at tail, tag_b at tail+1 (mod FL_SIZE) only when r==2.
REQ-021 Retire SHALL be accepted only while count-d+r <= FL_SIZE; surplus tags (tag_b first, then tag_a) SHALL be dropped, tail advances only by accepted count, fl_error set.
REQ-022 count_next = count - d + r_accepted, evaluated with the same-cycle d (dispatch frees slots before retire fills them).
REQ-023 Simultaneous dispatch and retire SHALL both take effect in the same cycle; head reads pre-update entries.
REQ-024 Retired tag SHALL become visible on fl_pr0/fl_pr1 no earlier than the cycle after retire.
REQ-025 fl_error SHALL remain 1 until reset once set.
REQ-026 Tags SHALL leave in FIFO order: retire order equals later dispatch order.

Reset
REQ-027 While reset==0 at posedge: mem[i]=PR_FIRST+i, head=0, tail=0, count=FL_SIZE, fl_error=0; dispatch/retire inputs ignored that cycle.
REQ-028 After reset: fl_pr0=PR_FIRST, fl_pr1=PR_FIRST+1, fl_cap=2, fl_count=FL_SIZE, fl_error=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight state and restore REQ-027 values in one cycle.

Verification
REQ-030 Reset, idle inputs -> fl_pr0=32, fl_pr1=33, fl_cap=2, fl_count=32, fl_error=0.
REQ-031 One cycle id_dispatch_num=2 -> next cycle fl_pr0=34, fl_pr1=35, fl_count=30; then id_dispatch_num=1 -> fl_pr0=35, fl_count=29.
REQ-032 Dispatch 2 for 16 cycles -> fl_count=0, fl_cap=0; further id_dispatch_num=2 -> head and count unchanged, no error.
REQ-033 At count 0, rob_retire_num=2, tags 4,5 -> same cycle fl_cap=0; next cycle fl_pr0=4, fl_pr1=5, fl_cap=2, fl_count=2.
REQ-034 From count 30 (head=2,tail=0), dispatch 2 + retire 2 (tags 32,33) every cycle for 20 cycles -> fl_count stays 30, head/tail wrap; dispatched tags follow 34..63, then 32,33,...; fl_error=0.
REQ-035 At count 32, rob_retire_num=1 tag 7 -> fl_count=32, fl_error=1 and stays 1; then reset=0 one cycle mid-operation -> REQ-028 values, fl_error=0.

Source files
------------

// File: rtl/free_list.sv
// Physical-register free list: a circular FIFO of tags handed to dispatch
// (up to two per cycle) and refilled by ROB retire (up to two per cycle).
// Dispatch is clamped to the tags on hand; retire beyond capacity is
// dropped (tag_b before tag_a) and raises a sticky error flag.
module free_list #(
    parameter int FL_SIZE  = 32,
    parameter int PR_FIRST = 32,
    parameter int TAG_W    = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 id_dispatch_num,
    input  logic [1:0]                 rob_retire_num,
    input  logic [TAG_W-1:0]           rob_retire_tag_a,
    input  logic [TAG_W-1:0]           rob_retire_tag_b,
    output logic [TAG_W-1:0]           fl_pr0,
    output logic [TAG_W-1:0]           fl_pr1,
    output logic [1:0]                 fl_cap,
    output logic [$clog2(FL_SIZE):0]   fl_count,
    output logic                       fl_error
);

    localparam int PTR_W = $clog2(FL_SIZE);
    localparam int CNT_W = PTR_W + 1;

    // A request code of 3 is not legal on either port; treat it as 2.
    function automatic logic [1:0] clamp_req(input logic [1:0] n);
        logic [1:0] res;
        case (n)
            2'd0:    res = 2'd0;
            2'd1:    res = 2'd1;
            2'd2:    res = 2'd2;
            2'd3:    res = 2'd2;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // Reset image of one storage entry: the free list starts full with
    // consecutive tags beginning at PR_FIRST.
    function automatic logic [TAG_W-1:0] reset_tag(input int idx);
        return TAG_W'(PR_FIRST + idx);
    endfunction

    // Registered state
    logic [TAG_W-1:0] mem_q [FL_SIZE];
    logic [TAG_W-1:0] mem_d [FL_SIZE];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    // Combinational helpers
    logic [PTR_W-1:0] head_p1_s;
    logic [PTR_W-1:0] tail_p1_s;
    logic [1:0]       cap_s;
    logic [1:0]       disp_req_s;
    logic [1:0]       disp_eff_s;
    logic [1:0]       ret_req_s;
    logic [1:0]       ret_acc_s;
    logic [CNT_W-1:0] after_disp_s;
    logic [CNT_W-1:0] room_s;
    logic             overflow_s;

    // Tags available this cycle and the dispatch count actually honoured.
    always_comb begin
        head_p1_s  = head_q + PTR_W'(1);
        tail_p1_s  = tail_q + PTR_W'(1);
        if (count_q >= CNT_W'(2)) begin
            cap_s = 2'd2;
        end else begin
            cap_s = count_q[1:0];
        end
        disp_req_s = clamp_req(id_dispatch_num);
        if (disp_req_s > cap_s) begin
            disp_eff_s = cap_s;
        end else begin
            disp_eff_s = disp_req_s;
        end
    end

    // Retire acceptance: dispatch frees its slots first, then retire may
    // fill up to the remaining room; anything beyond that is dropped.
    always_comb begin
        ret_req_s    = clamp_req(rob_retire_num);
        after_disp_s = count_q - CNT_W'(disp_eff_s);
        room_s       = CNT_W'(FL_SIZE) - after_disp_s;
        if (room_s >= CNT_W'(ret_req_s)) begin
            ret_acc_s = ret_req_s;
        end else begin
            ret_acc_s = room_s[1:0];
        end
        overflow_s = (ret_acc_s != ret_req_s);
    end

    // Next-state for storage, pointers, occupancy and the sticky error.
    always_comb begin
        for (int i = 0; i < FL_SIZE; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (ret_acc_s != 2'd0) begin
            mem_d[tail_q] = rob_retire_tag_a;
        end else begin
            mem_d[tail_q] = mem_q[tail_q];
        end
        if (ret_acc_s == 2'd2) begin
            mem_d[tail_p1_s] = rob_retire_tag_b;
        end else begin
            mem_d[tail_p1_s] = mem_d[tail_p1_s];
        end
        head_d  = head_q + PTR_W'(disp_eff_s);
        tail_d  = tail_q + PTR_W'(ret_acc_s);
        count_d = after_disp_s + CNT_W'(ret_acc_s);
        error_d = error_q | overflow_s;
    end

    // State update with synchronous active-low reset to a full list.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                mem_q[i] <= reset_tag(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(FL_SIZE);
            error_q <= 1'b0;
        end else begin
            for (int i = 0; i < FL_SIZE; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    // Outputs come straight from registered state; retired tags therefore
    // appear at the head no earlier than the following cycle.
    always_comb begin
        fl_pr0   = mem_q[head_q];
        fl_pr1   = mem_q[head_p1_s];
        fl_cap   = cap_s;
        fl_count = count_q;
        fl_error = error_q;
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset image, dispatch/clamp, retire at
// empty, steady-state wrap-around, overflow stickiness and mid-run reset.
module tb_free_list;

    logic       clock;
    logic       reset;
    logic [1:0] id_dispatch_num;
    logic [1:0] rob_retire_num;
    logic [6:0] rob_retire_tag_a;
    logic [6:0] rob_retire_tag_b;
    logic [6:0] fl_pr0;
    logic [6:0] fl_pr1;
    logic [1:0] fl_cap;
    logic [5:0] fl_count;
    logic       fl_error;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    free_list #(.FL_SIZE(32), .PR_FIRST(32), .TAG_W(7)) dut (
        .clock            (clock),
        .reset            (reset),
        .id_dispatch_num  (id_dispatch_num),
        .rob_retire_num   (rob_retire_num),
        .rob_retire_tag_a (rob_retire_tag_a),
        .rob_retire_tag_b (rob_retire_tag_b),
        .fl_pr0           (fl_pr0),
        .fl_pr1           (fl_pr1),
        .fl_cap           (fl_cap),
        .fl_count         (fl_count),
        .fl_error         (fl_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive(input int d, input int r, input int ta, input int tb);
        id_dispatch_num  = 2'(d);
        rob_retire_num   = 2'(r);
        rob_retire_tag_a = 7'(ta);
        rob_retire_tag_b = 7'(tb);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b1;

        // Reset image with idle inputs
        check("rst_pr0",   fl_pr0,   32);
        check("rst_pr1",   fl_pr1,   33);
        check("rst_cap",   fl_cap,   2);
        check("rst_count", fl_count, 32);
        check("rst_err",   fl_error, 0);

        // Dispatch 2, then dispatch 1
        drive(2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        check("d2_pr0",   fl_pr0,   34);
        check("d2_pr1",   fl_pr1,   35);
        check("d2_count", fl_count, 30);
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        check("d1_pr0",   fl_pr0,   35);
        check("d1_pr1",   fl_pr1,   36);
        check("d1_count", fl_count, 29);

        // Drain completely; code 3 behaves as 2
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive((i == 5) ? 3 : 2, 0, 0, 0);
            tick();
        end
        check("drain_count", fl_count, 0);
        check("drain_cap",   fl_cap,   0);
        drive(2, 0, 0, 0);
        tick();
        check("empty_disp_count", fl_count, 0);
        check("empty_disp_pr0",   fl_pr0,   32);
        check("empty_disp_err",   fl_error, 0);

        // Retire into an empty list: not visible until next cycle
        drive(0, 2, 4, 5);
        check("ret_same_cap", fl_cap, 0);
        tick();
        drive(0, 0, 0, 0);
        check("ret_pr0",   fl_pr0,   4);
        check("ret_pr1",   fl_pr1,   5);
        check("ret_cap",   fl_cap,   2);
        check("ret_count", fl_count, 2);

        // Retire then dispatch 1 at count 1: request of 2 clamps to 1
        drive(1, 0, 0, 0);
        tick();
        check("one_cap", fl_cap, 1);
        check("one_pr0", fl_pr0, 5);
        drive(2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        check("clamp_count", fl_count, 0);
        check("clamp_err",   fl_error, 0);

        // Simultaneous dispatch 3 (as 2) at empty and retire 3 (as 2)
        drive(3, 3, 8, 9);
        tick();
        drive(0, 0, 0, 0);
        check("both_count", fl_count, 2);
        check("both_pr0",   fl_pr0,   8);
        check("both_pr1",   fl_pr1,   9);

        // Fill to 30, then 31, then a partially accepted pair
        for (int i = 0; i < 14; i++) begin
            drive(0, 2, 10 + 2 * i, 11 + 2 * i);
            tick();
        end
        drive(0, 0, 0, 0);
        check("fill_count", fl_count, 30);
        check("fill_err",   fl_error, 0);
        drive(0, 1, 20, 0);
        tick();
        check("fill31_count", fl_count, 31);
        drive(0, 2, 40, 41);
        tick();
        drive(0, 0, 0, 0);
        check("part_count", fl_count, 32);
        check("part_err",   fl_error, 1);
        check("part_pr0",   fl_pr0,   8);

        // Retire into a full list: dropped, error stays set
        drive(0, 1, 7, 0);
        tick();
        drive(0, 0, 0, 0);
        check("full_count", fl_count, 32);
        check("full_err",   fl_error, 1);
        check("full_pr0",   fl_pr0,   8);
        tick();
        check("sticky_err", fl_error, 1);

        // Drain the refilled list in FIFO order
        exp_q = {8, 9};
        for (int i = 10; i < 38; i++) exp_q.push_back(i);
        exp_q.push_back(20);
        exp_q.push_back(40);
        for (int i = 0; i < 16; i++) begin
            check("fifo_pr0", fl_pr0, exp_q[0]);
            check("fifo_pr1", fl_pr1, exp_q[1]);
            drive(2, 0, 0, 0);
            tick();
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
        end
        drive(0, 0, 0, 0);
        check("fifo_count", fl_count, 0);

        // Reset mid-operation with active inputs
        reset = 1'b0;
        drive(1, 2, 1, 2);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        check("mid_rst_pr0",   fl_pr0,   32);
        check("mid_rst_pr1",   fl_pr1,   33);
        check("mid_rst_cap",   fl_cap,   2);
        check("mid_rst_count", fl_count, 32);
        check("mid_rst_err",   fl_error, 0);

        // Steady state from count 30: dispatch 2 + retire 32,33 with wrap
        drive(2, 0, 0, 0);
        tick();
        exp_q = {};
        for (int i = 34; i < 64; i++) exp_q.push_back(i);
        for (int i = 0; i < 20; i++) begin
            check("ss_pr0",   fl_pr0,   exp_q[0]);
            check("ss_pr1",   fl_pr1,   exp_q[1]);
            check("ss_count", fl_count, 30);
            drive(2, 2, 32, 33);
            tick();
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            exp_q.push_back(32);
            exp_q.push_back(33);
        end
        drive(0, 0, 0, 0);
        check("ss_end_count", fl_count, 30);
        check("ss_end_pr0",   fl_pr0,   exp_q[0]);
        check("ss_end_err",   fl_error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
